// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: FSM encoding and sizing helper shared by the UART transmit path
package uart_tx_fifo_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ARM, DRAIN} tx_state_e;
  function automatic int clog2w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU write port plus UART core load/txbusy handshake.
// tx_irq exists only when UART_TX_FIFO_IRQ_EN is defined.
interface uart_tx_fifo_if #(parameter int DEPTH = 16);
  logic wr_en;
  logic [7:0] wr_data;
  logic flush, overflow_clr, full, empty, overflow, uart_load, uart_txbusy;
  logic [$clog2(DEPTH):0] level;
  logic [7:0] uart_d;
`ifdef UART_TX_FIFO_IRQ_EN
  logic tx_irq;
`endif
  modport master (
`ifdef UART_TX_FIFO_IRQ_EN
    input tx_irq,
`endif
    output wr_en, wr_data, flush, overflow_clr, uart_txbusy,
    input full, empty, level, overflow, uart_load, uart_d
  );
  modport slave (
`ifdef UART_TX_FIFO_IRQ_EN
    output tx_irq,
`endif
    input wr_en, wr_data, flush, overflow_clr, uart_txbusy,
    output full, empty, level, overflow, uart_load, uart_d
  );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo_core.sv
// sync_fifo_core: byte storage with wrapping pointers and registered level/full/empty
module sync_fifo_core import uart_tx_fifo_pkg::*; #(parameter int DEPTH = 16) (
  input  logic clk,
  input  logic resetn,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic full_o,
  output logic empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = clog2w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic full_q, empty_q;
  always_comb begin
    wptr_d = flush_i ? '0 : wptr_q + AW'(push_i);
    rptr_d = flush_i ? '0 : rptr_q + AW'(pop_i);
    cnt_d = flush_i ? '0 : cnt_q + LW'(push_i) - LW'(pop_i);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      full_q <= cnt_d == LW'(DEPTH);
      empty_q <= cnt_d == '0;
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wptr_q] <= wdata_i;
  assign rdata_o = mem_q[rptr_q];
  assign full_o = full_q;
  assign empty_o = empty_q;
  assign level_o = cnt_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: CPU transmit FIFO feeding the UART core one byte per load pulse.
// Define UART_TX_FIFO_IRQ_EN to add the low-watermark tx_irq output.
module uart_tx_fifo import uart_tx_fifo_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int BUSY_WAIT = 4,
  parameter int LOW_WM = 4
) (
  input logic clk,
  input logic resetn,
  uart_tx_fifo_if.slave bus
);
  localparam int CW = clog2w(BUSY_WAIT);
  localparam int LW = $clog2(DEPTH) + 1;
  tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] d_q, d_d, rdata;
  logic load_q, ovf_q, ovf_d, push, pop, full, empty;
  logic [LW-1:0] level;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BUSY_WAIT < 1 || LOW_WM >= DEPTH) begin : g_bad_param
    $error("uart_tx_fifo: illegal parameter combination");
  end
  assign push = bus.wr_en && !full && !bus.flush;
  assign pop = load_q && !empty && !bus.flush;
  sync_fifo_core #(.DEPTH(DEPTH)) u_core (
    .clk(clk), .resetn(resetn), .push_i(push), .pop_i(pop), .flush_i(bus.flush),
    .wdata_i(bus.wr_data), .rdata_o(rdata), .full_o(full), .empty_o(empty), .level_o(level)
  );
  // a flush on the IDLE->LOAD edge cancels the load; an in-flight byte is left alone
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = (!empty && !bus.uart_txbusy && !bus.flush) ? LOAD : IDLE;
      LOAD: begin
        state_d = ARM;
        cnt_d = '0;
      end
      ARM: begin
        state_d = bus.uart_txbusy ? DRAIN : (cnt_q == CW'(BUSY_WAIT - 1)) ? IDLE : ARM;
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = bus.uart_txbusy ? DRAIN : IDLE;
    endcase
    d_d = (state_d == LOAD) ? rdata : d_q;
    ovf_d = (bus.wr_en && full && !bus.flush) || (ovf_q && !bus.overflow_clr);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      d_q <= 8'h00;
      load_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      d_q <= d_d;
      load_q <= state_d == LOAD;
      ovf_q <= ovf_d;
    end
`ifdef UART_TX_FIFO_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) irq_q <= 1'b0;
    else irq_q <= !bus.wr_en && level <= LW'(LOW_WM);
  assign bus.tx_irq = irq_q;
`endif
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.level = level;
  assign bus.overflow = ovf_q;
  assign bus.uart_load = load_q;
  assign bus.uart_d = d_q;
endmodule
